// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding and default widths.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIV    = 2'd1,
      RESULT = 2'd2
   } div_state_e;

   localparam int DW_DEFAULT = 32;
   localparam int CNT_W      = $clog2(DW_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract the divisor.
module div_step #(
   parameter int N = 16
) (
   input  logic [N:0]   rem_i,
   input  logic         bit_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   rem_o,
   output logic         q_o
);

   logic [N+1:0] shifted_s;
   logic [N:0]   diff_s;

   // The compare is one bit wider than the stored remainder so the shifted-out carry is never lost.
   assign shifted_s = {rem_i, bit_i};
   assign q_o       = (shifted_s >= {2'b00, divisor_i});
   assign diff_s    = shifted_s[N:0] - {1'b0, divisor_i};
   assign rem_o     = q_o ? diff_s : shifted_s[N:0];

endmodule

// File: rtl/shift_divider.sv
// Sequential restoring divider: one quotient bit per clock, accept/result_vld handshake.
module shift_divider
   import arith_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int N  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] dividend,
   input  logic [N-1:0]  divisor,
   input  logic          vld,
   output logic          busy,
   output logic [DW-1:0] quotient,
   output logic [N-1:0]  remainder,
   output logic          div_by_zero,
   output logic          result_vld
);

   localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]    rem_q, rem_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [N-1:0]  dsr_q, dsr_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [N-1:0]  remo_q, remo_d;
   logic          dbz_q, dbz_d;
   logic          rvld_q, rvld_d;
   logic          busy_q, busy_d;
   logic [N:0]    step_rem_s;
   logic          step_q_s;
   logic          div_zero_s;

   assign div_zero_s = (divisor == {N{1'b0}});

   div_step #(.N(N)) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[DW-1]),
      .divisor_i (dsr_q),
      .rem_o     (step_rem_s),
      .q_o       (step_q_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (vld) begin
               state_d = div_zero_s ? RESULT : DIV;
            end else begin
               state_d = IDLE;
            end
         end
         DIV: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RESULT;
            end else begin
               state_d = DIV;
            end
         end
         RESULT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values; results load on the edge entering RESULT.
   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      dvd_d  = dvd_q;
      dsr_d  = dsr_q;
      quot_d = quot_q;
      remo_d = remo_q;
      dbz_d  = dbz_q;
      rvld_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (vld) begin
               dvd_d = dividend;
               dsr_d = divisor;
               rem_d = {(N+1){1'b0}};
               cnt_d = {CW{1'b0}};
               if (div_zero_s) begin
                  quot_d = {DW{1'b1}};
                  remo_d = dividend[N-1:0];
                  dbz_d  = 1'b1;
                  rvld_d = 1'b1;
               end else begin
                  dbz_d  = 1'b0;
               end
            end else begin
               rvld_d = 1'b0;
            end
         end
         DIV: begin
            dvd_d = {dvd_q[DW-2:0], step_q_s};
            rem_d = step_rem_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               quot_d = {dvd_q[DW-2:0], step_q_s};
               remo_d = step_rem_s[N-1:0];
               rvld_d = 1'b1;
            end else begin
               rvld_d = 1'b0;
            end
         end
         RESULT:  rvld_d = 1'b0;
         default: rvld_d = 1'b0;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= {CW{1'b0}};
         rem_q  <= {(N+1){1'b0}};
         dvd_q  <= {DW{1'b0}};
         dsr_q  <= {N{1'b0}};
         quot_q <= {DW{1'b0}};
         remo_q <= {N{1'b0}};
         dbz_q  <= 1'b0;
         rvld_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dvd_q  <= dvd_d;
         dsr_q  <= dsr_d;
         quot_q <= quot_d;
         remo_q <= remo_d;
         dbz_q  <= dbz_d;
         rvld_q <= rvld_d;
         busy_q <= busy_d;
      end
   end

   assign busy        = busy_q;
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;
   assign result_vld  = rvld_q;

endmodule
